// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// It sits between the MEM stage load/store port and a req/ready word memory.
module dcache_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           A,
  input  logic                  RE,
  input  logic                  WE,
  input  logic [2:0]            AddressingControl,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, WRITE, DONE} state_t;
  state_t state, state_next;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [1:0]            off;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            mode;
  logic                  bad_align;
  logic                  hit;
  logic [31:0]           shifted;
  logic [31:0]           load_data;
  logic [3:0]            st_strb;
  logic [31:0]           st_wdata;
  logic [INDEX_BITS-1:0] m_idx;
  logic [TAG_BITS-1:0]   m_tag;
  logic                  fill;
  logic                  write_hit;
  logic                  unused_hi;

  assign unused_hi = ^A[31:ADDR_WIDTH];

  assign off       = A[1:0];
  assign idx       = A[INDEX_BITS+1:2];
  assign tag       = A[ADDR_WIDTH-1:INDEX_BITS+2];
  assign mode      = AddressingControl[1:0];
  assign bad_align = (mode == 2'b11) || (mode == 2'b01 && off[0]) ||
                     (mode == 2'b10 && off != 2'b00);
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);

  // Line bookkeeping follows the registered request, not the core inputs.
  assign m_idx     = mem_addr[INDEX_BITS+1:2];
  assign m_tag     = mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill      = (state == MISS) && mem_ready;
  assign write_hit = (state == WRITE) && mem_ready && valid_q[m_idx] &&
                     (tag_q[m_idx] == m_tag);

  always_comb begin
    shifted   = data_q[idx] >> {off, 3'b000};
    load_data = shifted;
    case (mode)
      2'b00:   load_data = AddressingControl[2] ? {24'h0, shifted[7:0]}
                                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = AddressingControl[2] ? {16'h0, shifted[15:0]}
                                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    st_strb  = 4'hF;
    st_wdata = WD;
    case (mode)
      2'b00: begin
        st_strb  = 4'b0001 << off;
        st_wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << off;
        st_wdata = {2{WD[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (WE && !bad_align)             state_next = WRITE;
        else if (RE && !bad_align && !hit) state_next = MISS;
      end
      MISS:    if (mem_ready) state_next = IDLE;
      WRITE:   if (mem_ready) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs are forced quiet while reset is held.
  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    RD         = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (RE || WE) begin
            if (bad_align) misaligned = 1'b1;
            else if (WE)   stall = 1'b1;
            else if (hit)  RD = load_data;
            else           stall = 1'b1;
          end
        end
        MISS, WRITE: stall = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (WE && !bad_align) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {A[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wstrb <= st_strb;
          end else if (RE && !bad_align && !hit) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {A[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb <= 4'h0;
          end
        end
        MISS, WRITE: if (mem_ready) mem_req <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    valid_q <= '0;
    else if (fill) valid_q[m_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[m_idx]  <= m_tag;
      data_q[m_idx] <= mem_rdata;
    end else if (write_hit) begin
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) data_q[m_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: a word memory model plus a valid/tag picture of the cache
// predict load data, stall lengths and memory traffic for directed and random accesses.
module tb_dcache_wt;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A;
  logic        RE, WE;
  logic [2:0]  AddressingControl;
  logic [31:0] WD, RD;
  logic        stall, misaligned;
  logic        mem_req, mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  dcache_wt dut (
    .clk(clk), .rst_n(rst_n), .A(A), .RE(RE), .WE(WE),
    .AddressingControl(AddressingControl), .WD(WD), .RD(RD),
    .stall(stall), .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mm [int];
  logic        cv [64];
  logic [8:0]  ct [64];
  int          req_count = 0;
  int          exp_req_count = 0;
  int          last_delay = 0;
  int          forced_delay = -1;
  logic        hold_ready = 1'b0;
  logic        exp_we;
  logic [16:0] exp_addr;
  logic [3:0]  exp_wstrb;
  logic [31:0] exp_wdata;
  logic [3:0]  got_wstrb;
  logic [31:0] got_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input int w);
    if (mm.exists(w)) return mm[w];
    return (32'(w) * 32'h9E3779B1) ^ 32'hA5C30F17;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] m,
                                           input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * off);
    case (m[1:0])
      2'b00:   return m[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      2'b01:   return m[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory responder: random latency, stray mem_ready while idle, field stability checks.
  initial begin : responder
    logic        active;
    int          wait_left;
    logic [16:0] cap_addr;
    logic        cap_we;
    logic [3:0]  cap_strb;
    logic [31:0] cap_wdata;
    logic [31:0] old;
    active = 1'b0; wait_left = 0; mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          req_count++;
          wait_left = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
          last_delay = wait_left;
          cap_addr = mem_addr; cap_we = mem_we; cap_strb = mem_wstrb; cap_wdata = mem_wdata;
          got_wstrb = mem_wstrb; got_wdata = mem_wdata;
          check("mem_we", mem_we, exp_we);
          check("mem_addr", mem_addr, exp_addr);
          if (exp_we) begin
            check("mem_wstrb", mem_wstrb, exp_wstrb);
            check("mem_wdata", mem_wdata, exp_wdata);
          end
        end else begin
          check("hold_addr", mem_addr, cap_addr);
          check("hold_we", mem_we, cap_we);
          if (cap_we) begin
            check("hold_wstrb", mem_wstrb, cap_strb);
            check("hold_wdata", mem_wdata, cap_wdata);
          end
        end
        if (hold_ready) begin
          mem_ready = 1'b0;
        end else if (wait_left == 0) begin
          mem_ready = 1'b1;
          active = 1'b0;
          if (exp_we) begin
            old = mem_word(int'(exp_addr[16:2]));
            for (int i = 0; i < 4; i++)
              if (exp_wstrb[i]) old[8*i +: 8] = exp_wdata[8*i +: 8];
            mm[int'(exp_addr[16:2])] = old;
          end else begin
            mem_rdata = mem_word(int'(exp_addr[16:2]));
          end
        end else begin
          mem_ready = 1'b0;
          wait_left--;
        end
      end else begin
        active = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      RE = 1'b0;
      WE = 1'b0;
    end
  endtask

  task automatic access(input logic we, input logic re, input logic [2:0] mode,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd_got, output int stalls);
    logic [1:0]  off;
    int          idx;
    logic [8:0]  tg;
    logic        mis, hit;
    off = a[1:0];
    idx = int'(a[7:2]);
    tg  = a[16:8];
    mis = (mode[1:0] == 2'b11) || (mode[1:0] == 2'b01 && off[0]) ||
          (mode[1:0] == 2'b10 && off != 2'b00);
    hit = cv[idx] && (ct[idx] == tg);
    @(negedge clk);
    exp_we   = we;
    exp_addr = {a[16:2], 2'b00};
    case (mode[1:0])
      2'b00:   begin exp_wstrb = 4'b0001 << off; exp_wdata = {4{wd[7:0]}}; end
      2'b01:   begin exp_wstrb = 4'b0011 << off; exp_wdata = {2{wd[15:0]}}; end
      default: begin exp_wstrb = 4'hF; exp_wdata = wd; end
    endcase
    A = a; WE = we; RE = re; AddressingControl = mode; WD = wd;
    stalls = 0;
    #1;
    check("req_count", req_count, exp_req_count);
    while (stall === 1'b1) begin
      stalls++;
      if (stalls > 40) begin
        n_checks++; n_fail++;
        $display("FAIL stall_timeout: stall still 1 after %0d cycles, required release", stalls);
        break;
      end
      @(negedge clk);
      #1;
    end
    rd_got = RD;
    check("misaligned", misaligned, mis);
    if (mis) begin
      check("rd_misaligned", RD, 0);
      check("stall_misaligned", stalls, 0);
    end else if (we) begin
      exp_req_count++;
      check("store_stalls", stalls, last_delay + 2);
    end else if (re) begin
      check("rd", RD, load_val(mem_word(int'(a[16:2])), mode, off));
      if (hit) begin
        check("hit_stalls", stalls, 0);
      end else begin
        exp_req_count++;
        check("miss_stalls", stalls, last_delay + 2);
        cv[idx] = 1'b1;
        ct[idx] = tg;
      end
    end
  endtask

  initial begin : main
    logic [31:0] rd;
    int          st;
    int          op;
    logic [31:0] a;
    logic [2:0]  m;
    for (int i = 0; i < 64; i++) begin cv[i] = 1'b0; ct[i] = '0; end
    rst_n = 1'b0; RE = 1'b1; WE = 1'b0; A = 32'h10000; AddressingControl = 3'b010; WD = '0;
    #3;
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_misaligned", misaligned, 0);
    check("rst_rd", RD, 0);
    @(negedge clk);
    RE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    mm[32'h10000 >> 2] = 32'hDEADBEEF;
    forced_delay = 1;
    access(0, 1, 3'b010, 32'h10000, 0, rd, st);
    check("lit_lw_rd", rd, 32'hDEADBEEF);
    check("lit_lw_stalls", st, 3);
    access(0, 1, 3'b010, 32'h10000, 0, rd, st);
    check("lit_rehit_stalls", st, 0);
    access(0, 1, 3'b000, 32'h10003, 0, rd, st);
    check("lit_lb", rd, 32'hFFFFFFDE);
    access(0, 1, 3'b100, 32'h10003, 0, rd, st);
    check("lit_lbu", rd, 32'h000000DE);
    access(0, 1, 3'b001, 32'h10002, 0, rd, st);
    check("lit_lh", rd, 32'hFFFFDEAD);
    access(0, 1, 3'b101, 32'h10002, 0, rd, st);
    check("lit_lhu", rd, 32'h0000DEAD);

    forced_delay = 0;
    access(1, 0, 3'b000, 32'h10001, 32'h00000012, rd, st);
    check("lit_sb_wstrb", got_wstrb, 4'b0010);
    check("lit_sb_wdata", got_wdata, 32'h12121212);
    access(0, 1, 3'b010, 32'h10000, 0, rd, st);
    check("lit_merge_rd", rd, 32'hDEAD12EF);
    check("lit_merge_stalls", st, 0);
    access(1, 0, 3'b010, 32'h10040, 32'hCAFEF00D, rd, st);
    access(0, 1, 3'b010, 32'h10040, 0, rd, st);
    check("lit_nwa_stalls", st, 2);
    check("lit_nwa_rd", rd, 32'hCAFEF00D);

    access(0, 1, 3'b001, 32'h10001, 0, rd, st);
    access(0, 1, 3'b010, 32'h10002, 0, rd, st);
    access(0, 1, 3'b011, 32'h10000, 0, rd, st);
    access(1, 0, 3'b001, 32'h10003, 32'h5555, rd, st);
    idle(1);

    hold_ready = 1'b1;
    @(negedge clk);
    A = 32'h10080; RE = 1'b1; WE = 1'b0; AddressingControl = 3'b010;
    exp_we = 1'b0; exp_addr = 17'h10080;
    repeat (3) @(negedge clk);
    #1;
    check("miss_hold_req", mem_req, 1);
    check("miss_hold_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check("midmiss_rst_req", mem_req, 0);
    check("midmiss_rst_stall", stall, 0);
    exp_req_count++;
    RE = 1'b0;
    for (int i = 0; i < 64; i++) cv[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold_ready = 1'b0;
    forced_delay = -1;
    access(0, 1, 3'b010, 32'h10080, 0, rd, st);
    check("rst_refetch_missed", 32'(st >= 2), 1);

    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 9);
      m  = 3'($urandom_range(0, 7));
      a  = (32'($urandom_range(0, 3)) << 17) | 32'h10000 |
           (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2) |
           32'($urandom_range(0, 3));
      if (op < 3)       access(1, 0, m, a, $urandom(), rd, st);
      else if (op == 9) access(1, 1, m, a, $urandom(), rd, st);
      else              access(0, 1, m, a, 0, rd, st);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    #1;
    check("final_req_count", req_count, exp_req_count);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end
endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipelined core's MEM stage and the byte-addressed data memory.
- Presents the same load/store interface the MEM stage already drives: address, write enable, 3-bit addressing control, write data and read data.
- Adds a read enable and a stall output towards the hazard unit.
- Talks to a word-wide memory port through a req/ready handshake with byte strobes.

Parameters:
- DATA_WIDTH, 32, CPU and memory data width (fixed at 32).
- ADDR_WIDTH, 17, significant address bits (data region 0x00000-0x1FFFF).
- INDEX_BITS, 6, log2 of line count. The line is one 32-bit word, so the cache has 64 lines.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- A  in  32  byte address from the MEM stage. Only [ADDR_WIDTH-1:0] is used.
- RE  in  1  load request.
- WE  in  1  store request. It has priority over RE.
- AddressingControl  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 illegal. [2] selects zero-extend on loads.
- WD  in  32  store data, right-aligned.
- RD  out  32  load data, extended per AddressingControl.
- stall  out  1  high while the current access cannot complete. The core holds all inputs stable while stall=1.
- misaligned  out  1  single-cycle flag: the access is not naturally aligned, or the mode is 11.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1=write, 0=read-fill.
- mem_addr  out  17  word-aligned address, bits [1:0]=0.
- mem_wdata  out  32  write data, lane-aligned.
- mem_wstrb  out  4  byte strobes.
- mem_rdata  in  32  fill data. Valid when mem_ready=1.
- mem_ready  in  1  memory completes the request this cycle.

Behaviour:
- Address split:
  - offset = A[1:0]
  - index = A[INDEX_BITS+1:2]
  - tag = A[ADDR_WIDTH-1:INDEX_BITS+2], 9 bits with the defaults
- Storage per line: valid bit, tag, 32-bit data.
- Reset (async, rst_n=0):
  - all valid bits cleared, FSM to IDLE.
  - outputs: stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, misaligned=0, RD=0.
  - Reset during MISS or WRITE abandons the transaction. The line is not filled.
- Alignment rules:
  - Half accesses need offset[0]=0. Word accesses need offset=00.
  - A violating access, or mode 11, sets misaligned=1 combinationally, RD=0 and stall=0.
  - No memory request is made and no state changes.
- Lane mapping for stores:
  - Byte: wstrb=0001<<offset, wdata=WD[7:0] replicated to all lanes.
  - Half: wstrb=0011<<offset, wdata=WD[15:0] replicated.
  - Word: wstrb=1111, wdata=WD.
- Load extraction selects the byte or half at offset, then sign- or zero-extends per AddressingControl[2]. Word loads ignore bit 2.
- FSM states:
  - IDLE:
    - RE && !WE, hit (valid && tag match): RD valid combinationally the same cycle, stall=0. Zero-latency hit.
    - RE && !WE, miss: stall=1 the same cycle. Go to MISS and register mem_addr={A[16:2],2'b00}, mem_we=0, mem_req=1.
    - WE: stall=1 the same cycle. Go to WRITE and register mem_addr, mem_wdata, mem_wstrb, mem_we=1, mem_req=1.
    - Neither: stall=0, mem_req=0.
  - MISS:
    - mem_req=1, stall=1 until mem_ready.
    - On mem_ready: write the line (valid=1, tag, data=mem_rdata), mem_req=0, go to IDLE.
    - The next cycle the held load hits: stall=0, RD valid. A read miss therefore costs at least 2 stall cycles.
  - WRITE:
    - mem_req=1, stall=1 until mem_ready.
    - On mem_ready: if the line hits, merge the strobed bytes into the cached data. Misses do not allocate.
    - mem_req=0, then go to DONE.
  - DONE: stall=0 for one cycle so the core retires the store, then go to IDLE.
    - A store is not re-issued.
    - The DONE cycle ignores WE/RE. The core advances during it.
- Memory interface:
  - mem_req, mem_addr, mem_we, mem_wdata and mem_wstrb are held stable from assertion until the mem_ready cycle. They are registered outputs.
  - mem_ready seen while mem_req=0 is ignored.
  - mem_ready in the same cycle as mem_req first rises is legal and completes that cycle. Minimum one-cycle memory.
- Aliasing:
  - A fill overwrites any previous tag at that index.
  - Addresses differing only above ADDR_WIDTH alias by design.

Test Plan:
- Reset, then lw A=0x10000 with memory word 0xDEADBEEF, mem_ready after 2 cycles -> stall high 3 cycles (REQ + 2 wait), then RD=0xDEADBEEF with stall=0. An immediate repeat lw hits with no mem_req.
- After the fill above, lb A=0x10003 -> RD=0xFFFFFFDE. lbu -> 0x000000DE. lh A=0x10002 -> 0xFFFFDEAD. lhu -> 0x0000DEAD. All zero-latency.
- sb WD=0x12 to A=0x10001 on a hit line, 1-cycle ready -> mem_wstrb=0010, mem_wdata=0x12121212. The following lw A=0x10000 -> 0xDEAD12EF with no miss.
- sw to A=0x10040, which misses (index 16) -> memory write issued. A subsequent lw to 0x10040 misses and fills; confirms no-write-allocate.
- lh A=0x10001 or lw A=0x10002 -> misaligned=1 one cycle, RD=0, stall=0, no mem_req. Mode 11 -> misaligned=1.
- Assert rst_n=0 mid-MISS (mem_ready never given) -> mem_req and stall drop immediately. After release, lw to the same address misses again.
